// File: rtl/avalon_master_pkg.sv
// Shared types and helpers for the Avalon-MM write (and future read) masters.
// Holds the channel state encoding and byte-step arithmetic.
package avalon_master_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int BYTE_STEP_DEFAULT = 4;

    // Number of low address/length bits covered by one bus word.
    function automatic int step_log2(input int bytes_per_word);
        return $clog2(bytes_per_word);
    endfunction

endpackage

// File: rtl/avalon_write_master_if.sv
// Control, user-data and Avalon-MM signals of one write channel.
// The master modport is the write master's view; slave is the environment's.
interface avalon_write_master_if #(
    parameter int ADDRESSWIDTH    = 28,
    parameter int DATAWIDTH       = 32,
    parameter int BYTEENABLEWIDTH = 4
);
    logic                       control_fixed_location;
    logic [ADDRESSWIDTH-1:0]    control_write_base;
    logic [ADDRESSWIDTH-1:0]    control_write_length;
    logic                       control_go;
    logic                       control_done;
    logic                       user_write_buffer;
    logic [DATAWIDTH-1:0]       user_buffer_data;
    logic                       user_buffer_full;
    logic [ADDRESSWIDTH-1:0]    master_address;
    logic                       master_write;
    logic [BYTEENABLEWIDTH-1:0] master_byteenable;
    logic [DATAWIDTH-1:0]       master_writedata;
    logic                       master_waitrequest;

    modport master (
        input  control_fixed_location,
        input  control_write_base,
        input  control_write_length,
        input  control_go,
        output control_done,
        input  user_write_buffer,
        input  user_buffer_data,
        output user_buffer_full,
        output master_address,
        output master_write,
        output master_byteenable,
        output master_writedata,
        input  master_waitrequest
    );

    modport slave (
        output control_fixed_location,
        output control_write_base,
        output control_write_length,
        output control_go,
        input  control_done,
        output user_write_buffer,
        output user_buffer_data,
        input  user_buffer_full,
        input  master_address,
        input  master_write,
        input  master_byteenable,
        input  master_writedata,
        output master_waitrequest
    );
endinterface

// File: rtl/avalon_write_master_fifo.sv
// Small register-array FIFO buffering user write words ahead of the bus.
// Head is read combinationally so the bus sees the word as soon as it is stored.
module write_fifo #(
    parameter int DATAWIDTH      = 32,
    parameter int FIFODEPTH      = 8,
    parameter int FIFODEPTH_LOG2 = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DATAWIDTH-1:0] data,
    output logic [DATAWIDTH-1:0] head,
    output logic                 empty,
    output logic                 full
);
    logic [DATAWIDTH-1:0]      mem [FIFODEPTH];
    logic [FIFODEPTH_LOG2-1:0] rd_ptr_reg;
    logic [FIFODEPTH_LOG2-1:0] wr_ptr_reg;
    logic [FIFODEPTH_LOG2:0]   count_reg;
    logic                      push_ok;
    logic                      pop_ok;

    // Full is decoded from the current count, so a push while full is dropped
    // even when a pop happens in the same cycle.
    assign full    = (count_reg == (FIFODEPTH_LOG2 + 1)'(FIFODEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr_reg];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= data;
        end
    end

endmodule

// File: rtl/avalon_write_master.sv
// Avalon-MM write master: turns go/base/length requests into single-word
// writes fed from a small user FIFO, reporting completion on control_done.
module avalon_write_master
    import avalon_master_pkg::*;
#(
    parameter int ADDRESSWIDTH    = 28,
    parameter int DATAWIDTH       = 32,
    parameter int BYTEENABLEWIDTH = BYTE_STEP_DEFAULT,
    parameter int FIFODEPTH       = 8,
    parameter int FIFODEPTH_LOG2  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    avalon_write_master_if.master bus
);
    localparam int                    STEP_LOG2 = step_log2(BYTEENABLEWIDTH);
    localparam logic [ADDRESSWIDTH-1:0] STEP    = ADDRESSWIDTH'(BYTEENABLEWIDTH);
    localparam logic [ADDRESSWIDTH-1:0] LEN_MASK = ~(ADDRESSWIDTH'((1 << STEP_LOG2) - 1));

    state_t                  state_reg;
    state_t                  state_next;
    logic [ADDRESSWIDTH-1:0] address_reg;
    logic [ADDRESSWIDTH-1:0] remaining_reg;
    logic                    fixed_reg;

    logic [ADDRESSWIDTH-1:0] length_trunc;
    logic                    start;
    logic                    accept;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic [DATAWIDTH-1:0]    fifo_head;

    // Partial trailing words are dropped: only whole bus words are written.
    assign length_trunc = bus.control_write_length & LEN_MASK;
    assign accept       = bus.master_write && !bus.master_waitrequest;

    write_fifo #(
        .DATAWIDTH      (DATAWIDTH),
        .FIFODEPTH      (FIFODEPTH),
        .FIFODEPTH_LOG2 (FIFODEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.user_write_buffer),
        .pop   (accept),
        .data  (bus.user_buffer_data),
        .head  (fifo_head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        start      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.control_go && (length_trunc != '0)) begin
                    start      = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (accept && (remaining_reg == STEP)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Address only moves on an accepted beat, keeping it stable under stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            address_reg   <= '0;
            remaining_reg <= '0;
            fixed_reg     <= 1'b0;
        end else if (start) begin
            address_reg   <= bus.control_write_base;
            remaining_reg <= length_trunc;
            fixed_reg     <= bus.control_fixed_location;
        end else if (accept) begin
            remaining_reg <= remaining_reg - STEP;
            if (!fixed_reg) begin
                address_reg <= address_reg + STEP;
            end
        end
    end

    assign bus.control_done      = (state_reg == IDLE);
    assign bus.master_write      = (state_reg == RUN) && !fifo_empty;
    assign bus.master_address    = address_reg;
    assign bus.master_writedata  = fifo_head;
    assign bus.master_byteenable = '1;
    assign bus.user_buffer_full  = fifo_full;

endmodule
